// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchroniser, start-bit qualify at mid-bit, 8 data + stop sampled on sample_tick.
// rx_valid rises 1 clk after the stop sample; byte held until rx_ready, a newer byte arriving meanwhile is dropped (overrun).
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       sample_tick,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);

  // STOP_WAIT is the tail of STOP after a low stop sample: hold until the line returns high
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, STOP_WAIT} state_t;

  state_t          state, state_n;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shift_q, shift_n;
  logic [7:0]      data_n;
  logic            valid_n, fe_n, ov_n;
  logic            good_stop, bad_stop, xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_meta     <= uart_rx;
      rx_s        <= rx_meta;
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shift_q     <= shift_n;
      rx_data     <= data_n;
      rx_valid    <= valid_n;
      frame_error <= fe_n;
      overrun     <= ov_n;
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_M1) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == LAST) begin
            tick_n  = '0;
            bit_n   = bit_cnt + 3'd1;
            shift_n = MSB_FIRST ? {shift_q[6:0], rx_s} : {rx_s, shift_q[7:1]};
            if (bit_cnt == 3'd7) state_n = STOP;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == LAST) begin
            tick_n = '0;
            if (rx_s) begin
              good_stop = 1'b1;
              state_n   = IDLE;
            end else begin
              bad_stop = 1'b1;
              state_n  = STOP_WAIT;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        STOP_WAIT: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A transfer in the same cycle as a good stop frees the slot, so the new byte loads without overrun
  always_comb begin
    xfer    = rx_valid & rx_ready;
    data_n  = rx_data;
    valid_n = rx_valid & ~xfer;
    fe_n    = frame_error;
    ov_n    = overrun;
    if (xfer)     fe_n = 1'b0;
    if (bad_stop) fe_n = 1'b1;
    if (good_stop) begin
      if (!rx_valid || xfer) begin
        data_n  = shift_q;
        valid_n = 1'b1;
      end else begin
        ov_n = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a bench-side transmitter drives framed bytes, a monitor pops expected bytes on each transfer.
module tb_uart_receiver;

  localparam int OS   = 16;
  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_error, overrun, busy;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         vld_cycles = 0;
  int         run_len = 0;
  int         last_run = 0;

  uart_receiver #(.OVERSAMPLE(OS), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .sample_tick(sample_tick),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_error(frame_error), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TDIV - 1) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  // Monitor: every transfer pops the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        vld_cycles++;
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (rx_valid && rx_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %02h, scoreboard empty", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            n_fail++;
            $display("FAIL scoreboard_byte: got %02h, expected %02h", rx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_tick;
    @(posedge clk);
    while (sample_tick !== 1'b1) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (OS) wait_tick();
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still expected after %0d clk", name, exp_q.size(), t);
    end
  endtask

  task automatic pulse_reset;
    @(posedge clk);
    #1;
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    pulse_reset();
    @(negedge clk);
    n_checks++;
    if ({rx_valid, busy, frame_error, overrun} !== 4'b0000 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid/busy/fe/ov=%b data=%02h, expected 0000 00",
               {rx_valid, busy, frame_error, overrun}, rx_data);
    end
    vld_cycles = 0;
    idle_bits(50);
    n_checks++;
    if (vld_cycles !== 0) begin
      n_fail++;
      $display("FAIL idle_valid: rx_valid high %0d cycles, expected 0", vld_cycles);
    end
    n_checks++;
    if ({rx_valid, busy, frame_error, overrun} !== 4'b0000 || rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_state: valid/busy/fe/ov=%b data=%02h, expected 0000 00",
               {rx_valid, busy, frame_error, overrun}, rx_data);
    end
  endtask

  task automatic test_single_byte;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle_bits(2);
    wait_drain("single");
    n_checks++;
    if (last_run !== 1) begin
      n_fail++;
      $display("FAIL single_valid_width: rx_valid high %0d clk, expected 1", last_run);
    end
    n_checks++;
    if (frame_error !== 1'b0 || rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_state: fe=%b data=%02h, expected 0 a5", frame_error, rx_data);
    end
  endtask

  task automatic test_start_glitch;
    vld_cycles = 0;
    uart_rx = 1'b0;
    repeat (4) wait_tick();
    uart_rx = 1'b1;
    repeat (20) wait_tick();
    n_checks++;
    if (busy !== 1'b0 || vld_cycles !== 0) begin
      n_fail++;
      $display("FAIL glitch_reject: busy=%b valid_cycles=%0d, expected 0 0", busy, vld_cycles);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_bits(2);
    wait_drain("glitch_follow");
  endtask

  task automatic test_frame_error;
    rx_ready = 1'b0;
    vld_cycles = 0;
    send_frame(8'h55, 1'b0);
    idle_bits(2);
    n_checks++;
    if (frame_error !== 1'b1 || rx_valid !== 1'b0 || vld_cycles !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_error_set: fe=%b valid=%b valid_cycles=%0d busy=%b, expected 1 0 0 0",
               frame_error, rx_valid, vld_cycles, busy);
    end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle_bits(1);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h0F || frame_error !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_error_hold: valid=%b data=%02h fe=%b, expected 1 0f 1",
               rx_valid, rx_data, frame_error);
    end
    rx_ready = 1'b1;
    wait_drain("frame_error");
    repeat (2) @(negedge clk);
    n_checks++;
    if (frame_error !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_error_clear: fe=%b valid=%b, expected 0 0", frame_error, rx_valid);
    end
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(2);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: valid=%b data=%02h ov=%b, expected 1 11 1", rx_valid, rx_data, overrun);
    end
    rx_ready = 1'b1;
    wait_drain("overrun");
    idle_bits(3);
    n_checks++;
    if (rx_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: valid=%b ov=%b, expected 0 1", rx_valid, overrun);
    end
    pulse_reset();
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_reset: ov=%b, expected 0", overrun);
    end
  endtask

  task automatic test_back_to_back;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    wait_drain("loopback");
    n_checks++;
    if (rx_data !== 8'h81 || overrun !== 1'b0 || frame_error !== 1'b0) begin
      n_fail++;
      $display("FAIL loopback_final: data=%02h ov=%b fe=%b, expected 81 0 0", rx_data, overrun, frame_error);
    end
  endtask

  task automatic test_reset_mid_frame;
    vld_cycles = 0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy: busy=%b, expected 1", busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: busy=%b valid=%b, expected 0 0", busy, rx_valid);
    end
    idle_bits(15);
    n_checks++;
    if (vld_cycles !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_abort: valid_cycles=%0d busy=%b, expected 0 0", vld_cycles, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_start_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
